mul_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit for the MIPS execute stage, the sequential successor to the single-cycle adder/incrementer arithmetic. It runs MULT, MULTU, DIV and DIVU over LEN-bit operands in LEN+1 cycles, one bit per cycle. It owns the HI/LO architectural registers, including MTHI/MTLO writes. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mul_div_unit_pkg.sv | 28 ++
 rtl/mul_div_unit_addsub.sv | 18 +
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and the default operand width.
package mul_div_unit_pkg;

    localparam int LEN_WORD = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_addsub.sv
// Combinational W-bit adder/subtractor shared by the multiply-add and
// divide-subtract steps; o_carry set on subtract means i_a >= i_b.
module mdu_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);

    logic [W-1:0] w_b;

    assign w_b = i_sub ? ~i_b : i_b;
    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One bit per CALC cycle on magnitudes; sign fix-up happens in FIX.
//
// state  | meaning
// S_IDLE | waiting for i_start; MTHI/MTLO writes accepted
// S_CALC | LEN shift-add / shift-subtract iterations
// S_FIX  | sign correction, HI/LO write, done pulse next cycle
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int LEN = LEN_WORD
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [1:0]     i_op,
    input  logic [LEN-1:0] i_num_1,
    input  logic [LEN-1:0] i_num_2,
    input  logic           i_hi_we,
    input  logic           i_lo_we,
    input  logic [LEN-1:0] i_wr_data,
    output logic           o_busy,
    output logic           o_done,
    output logic [LEN-1:0] o_hi,
    output logic [LEN-1:0] o_lo
);

    localparam int CW = $clog2(LEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(LEN - 1);

    mdu_state_e       r_state;
    mdu_state_e       w_next;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_div0;
    logic [LEN-1:0]   r_a;
    logic [LEN-1:0]   r_b;
    logic [2*LEN-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [LEN-1:0]   r_hi;
    logic [LEN-1:0]   r_lo;
    logic             r_done;

    logic             w_signed;
    logic             w_div;
    logic [LEN-1:0]   w_abs_1;
    logic [LEN-1:0]   w_abs_2;
    logic [LEN-1:0]   w_acc_hi;
    logic [LEN:0]     w_as_a;
    logic [LEN:0]     w_as_b;
    logic             w_as_sub;
    logic [LEN:0]     w_sum;
    logic             w_carry;
    logic [2*LEN-1:0] w_acc_nxt;
    logic [2*LEN-1:0] w_prod;
    logic [LEN-1:0]   w_quo;
    logic [LEN-1:0]   w_rem;

    assign w_signed = op_is_signed(i_op);
    assign w_div    = op_is_div(i_op);
    assign w_abs_1  = (w_signed && i_num_1[LEN-1]) ? -i_num_1 : i_num_1;
    assign w_abs_2  = (w_signed && i_num_2[LEN-1]) ? -i_num_2 : i_num_2;
    assign w_acc_hi = r_acc[2*LEN-1:LEN];

    // Divide walks dividend bits out of r_a; multiply walks multiplier bits out of r_b.
    always_comb begin
        w_as_a    = {1'b0, w_acc_hi};
        w_as_b    = r_b[0] ? {1'b0, r_a} : '0;
        w_as_sub  = 1'b0;
        w_acc_nxt = '0;
        if (r_is_div) begin
            w_as_a    = {w_acc_hi, r_a[LEN-1]};
            w_as_b    = {1'b0, r_b};
            w_as_sub  = 1'b1;
            w_acc_nxt = {(w_carry ? w_sum[LEN-1:0] : w_as_a[LEN-1:0]),
                         r_acc[LEN-2:0], w_carry};
        end else begin
            w_acc_nxt = {w_sum, r_acc[LEN-1:1]};
        end
    end

    mdu_addsub #(.W(LEN + 1)) u_addsub (
        .i_a     (w_as_a),
        .i_b     (w_as_b),
        .i_sub   (w_as_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Divide by zero leaves the all-ones quotient unsigned.
    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = (r_neg_res && !r_div0) ? -r_acc[LEN-1:0] : r_acc[LEN-1:0];
    assign w_rem  = r_neg_rem ? -w_acc_hi : w_acc_hi;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_CALC;
            S_CALC:  if (r_cnt == LAST_ITER) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_hi_we) r_hi <= i_wr_data;
                    if (i_lo_we) r_lo <= i_wr_data;
                    if (i_start) begin
                        r_is_div  <= w_div;
                        r_neg_res <= w_signed & (i_num_1[LEN-1] ^ i_num_2[LEN-1]);
                        r_neg_rem <= w_signed & w_div & i_num_1[LEN-1];
                        r_div0    <= w_div & (i_num_2 == '0);
                        r_a       <= w_abs_1;
                        r_b       <= w_abs_2;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_is_div) r_a <= r_a << 1;
                    else          r_b <= r_b >> 1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*LEN-1:LEN];
                        r_lo <= w_prod[LEN-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic [31:0] n1, n2, wr;
    logic        start32, start8, hi_we, lo_we;
    logic        busy32, done32, busy8, done8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.LEN(32)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start32), .i_op(op),
        .i_num_1(n1), .i_num_2(n2), .i_hi_we(hi_we), .i_lo_we(lo_we),
        .i_wr_data(wr), .o_busy(busy32), .o_done(done32), .o_hi(hi32), .o_lo(lo32)
    );

    mul_div_unit #(.LEN(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_start(start8), .i_op(op),
        .i_num_1(n1[7:0]), .i_num_2(n2[7:0]), .i_hi_we(1'b0), .i_lo_we(1'b0),
        .i_wr_data(8'h00), .o_busy(busy8), .o_done(done8), .o_hi(hi8), .o_lo(lo8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on a w-bit machine.
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
        longint mask, ua, ub, sa, sb, q, r;
        logic [63:0] p;
        mask = (longint'(1) << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        p = '0;
        hi = '0;
        lo = '0;
        case (o)
            OP_MULT:  p = sa * sb;
            OP_MULTU: p = 64'(ua) * 64'(ub);
            OP_DIV: begin
                if (sb == 0) begin q = mask; r = ua; end
                else begin q = sa / sb; r = sa % sb; end
                hi = 32'(r & mask);
                lo = 32'(q & mask);
            end
            default: begin
                if (ub == 0) begin q = mask; r = ua; end
                else begin q = ua / ub; r = ua % ub; end
                hi = 32'(r & mask);
                lo = 32'(q & mask);
            end
        endcase
        if (o == OP_MULT || o == OP_MULTU) begin
            hi = 32'((p >> w) & 64'(mask));
            lo = 32'(p & 64'(mask));
        end
    endfunction

    // Launch one op in cycle 0 and check busy window, done cycle, result, single pulse.
    task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input string name);
        int len = w8 ? 8 : 32;
        int dcyc = -1;
        bit busy_ok = 1'b1;
        logic [31:0] ghi = 'x;
        logic [31:0] glo = 'x;
        logic bz, dn;
        @(posedge clk); #1;
        op = o; n1 = a; n2 = b;
        if (w8) start8 = 1'b1; else start32 = 1'b1;
        for (int c = 1; c <= len + 6 && dcyc < 0; c++) begin
            @(posedge clk); #1;
            start8 = 1'b0; start32 = 1'b0;
            if (c == 1) begin n1 = $urandom; n2 = $urandom; op = 2'($urandom); end
            @(negedge clk);
            bz = w8 ? busy8 : busy32;
            dn = w8 ? done8 : done32;
            if (bz !== (c <= len + 1)) busy_ok = 1'b0;
            if (dn === 1'b1) begin
                dcyc = c;
                ghi = w8 ? {24'h0, hi8} : hi32;
                glo = w8 ? {24'h0, lo8} : lo32;
            end
        end
        chk({name, " done_cycle"}, 64'(dcyc), 64'(len + 2));
        chk({name, " busy_window"}, 64'(busy_ok), 64'd1);
        chk({name, " hi"}, 64'(ghi), 64'(ehi));
        chk({name, " lo"}, 64'(glo), 64'(elo));
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, " done_single"}, 64'(w8 ? done8 : done32), 64'd0);
    endtask

    initial begin
        vec_t tv[14];
        logic [31:0] ehi, elo, ra, rb;
        logic [1:0]  rop;
        int ndone, dcyc;

        tv[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tv[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        tv[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        tv[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tv[5]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tv[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        tv[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tv[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        tv[9]  = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        tv[10] = '{OP_DIVU,  32'h12345678, 32'h00001000, 32'h00000678, 32'h00012345};
        tv[11] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        tv[12] = '{OP_DIV,   32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF};
        tv[13] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        rst = 1'b1; op = OP_MULT; n1 = '0; n2 = '0; wr = '0;
        start32 = 1'b0; start8 = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset done", 64'(done32), 64'd0);
        chk("reset hi", 64'(hi32), 64'd0);
        chk("reset lo", 64'(lo32), 64'd0);
        rst = 1'b0;

        // MTLO in IDLE lands next edge without a done pulse.
        @(posedge clk); #1;
        lo_we = 1'b1; wr = 32'hABCD;
        @(posedge clk); #1;
        lo_we = 1'b0;
        @(negedge clk);
        chk("mtlo lo", 64'(lo32), 64'hABCD);
        chk("mtlo no_done", 64'(done32), 64'd0);

        foreach (tv[i]) run_op(1'b0, tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo,
                               $sformatf("vec%0d", i));

        // Ignored restart at 5, dropped MTHI at 10, back-to-back start at LEN+2.
        @(posedge clk); #1;
        hi_we = 1'b1; wr = 32'h5555;
        @(posedge clk); #1;
        hi_we = 1'b0;
        op = OP_MULTU; n1 = 32'd3; n2 = 32'd4; start32 = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clk); #1;
            start32 = 1'b0; hi_we = 1'b0;
            if (c == 5)  begin start32 = 1'b1; op = OP_DIVU; n1 = 32'd100; n2 = 32'd3; end
            if (c == 10) begin hi_we = 1'b1; wr = 32'h1234; end
            if (c == 34) begin start32 = 1'b1; op = OP_DIVU; n1 = 32'd100; n2 = 32'd7; end
            @(negedge clk);
            if (c == 11) chk("busy mthi dropped", 64'(hi32), 64'h5555);
            if (done32 === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    chk("seq first done_cycle", 64'(c), 64'd34);
                    chk("seq first hi", 64'(hi32), 64'd0);
                    chk("seq first lo", 64'(lo32), 64'd12);
                end else begin
                    chk("seq b2b done_cycle", 64'(c), 64'd68);
                    chk("seq b2b hi", 64'(hi32), 64'd2);
                    chk("seq b2b lo", 64'(lo32), 64'd14);
                end
            end
        end
        chk("seq done count", 64'(ndone), 64'd2);

        // MTLO together with start: write lands, result overwrites later.
        @(posedge clk); #1;
        op = OP_MULT; n1 = 32'hFFFFFFFD; n2 = 32'd5; start32 = 1'b1; lo_we = 1'b1; wr = 32'h77;
        @(posedge clk); #1;
        start32 = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        chk("start+mtlo lo", 64'(lo32), 64'h77);
        chk("start+mtlo busy", 64'(busy32), 64'd1);
        dcyc = -1;
        for (int c = 2; c <= 40 && dcyc < 0; c++) begin
            @(negedge clk);
            if (done32 === 1'b1) dcyc = c;
        end
        chk("start+mtlo done_cycle", 64'(dcyc), 64'd34);
        chk("start+mtlo result lo", 64'(lo32), 64'hFFFFFFF1);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                default: rb = $urandom;
            endcase
            model(32, rop, ra, rb, ehi, elo);
            run_op(1'b0, rop, ra, rb, ehi, elo, $sformatf("rnd%0d", i));
        end

        // Reset in cycle 10 of a MULT clears everything at once; no done follows.
        @(posedge clk); #1;
        op = OP_MULT; n1 = 32'h1234; n2 = 32'h5678; start32 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start32 = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midreset busy", 64'(busy32), 64'd0);
        chk("midreset done", 64'(done32), 64'd0);
        chk("midreset hi", 64'(hi32), 64'd0);
        chk("midreset lo", 64'(lo32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1 || busy32 === 1'b1) ndone++;
        end
        chk("midreset quiet", 64'(ndone), 64'd0);
        run_op(1'b0, OP_MULT, 32'h1234, 32'h5678, 32'h0, 32'h06260060, "after_reset");

        run_op(1'b1, OP_DIVU, 32'd200, 32'd7, 32'd4, 32'd28, "len8 divu");
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom);
            ra = 32'($urandom_range(0, 255));
            rb = (i % 4 == 0) ? 32'h0 : 32'($urandom_range(0, 255));
            model(8, rop, ra, rb, ehi, elo);
            run_op(1'b1, rop, ra, rb, ehi, elo, $sformatf("len8 rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
